// File: rtl/rv_exec_unit.sv
// RV32I execute slice: decode, operand select, ALU, registered writeback.
// Define EXEC_TRACE_EN to print a per-cycle execution trace.
module rv_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     cmd,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [XLEN-1:0] imm,
  output logic [2:0]      op_imm,
  output logic            en_wreg,
  output logic            en_wmem,
  output logic            branch,
  output logic            load,
  output logic [3:0]      alu_sel,
  output logic [XLEN-1:0] result,
  output logic            is_zero,
  output logic [XLEN-1:0] result_q,
  output logic            wen_q
);

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_SLL   = 4'b0010,
    ALU_SLT   = 4'b0011,
    ALU_SLTU  = 4'b0100,
    ALU_XOR   = 4'b0101,
    ALU_SRL   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_OR    = 4'b1000,
    ALU_AND   = 4'b1001,
    ALU_COPYB = 4'b1010
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I    = 3'b000,
    IMM_S    = 3'b001,
    IMM_B    = 3'b010,
    IMM_U    = 3'b011,
    IMM_J    = 3'b100,
    IMM_NONE = 3'b111
  } imm_e;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic       f7;

  assign opcode = cmd[6:0];
  assign f3     = cmd[14:12];
  assign f7     = cmd[30];

  logic unused_cmd;
  assign unused_cmd = ^{cmd[31], cmd[29:15], cmd[11:7]};

  logic is_op, is_opi, is_lui, is_auipc;
  logic is_jal, is_jalr, is_load, is_store, is_br;

  assign is_op    = opcode == 7'b0110011;
  assign is_opi   = opcode == 7'b0010011;
  assign is_lui   = opcode == 7'b0110111;
  assign is_auipc = opcode == 7'b0010111;
  assign is_jal   = opcode == 7'b1101111;
  assign is_jalr  = opcode == 7'b1100111;
  assign is_load  = opcode == 7'b0000011;
  assign is_store = opcode == 7'b0100011;
  assign is_br    = opcode == 7'b1100011;

  function automatic alu_op_e f3_op(
    input logic [2:0] fn,
    input logic       alt
  );
    alu_op_e r;
    unique case (fn)
      3'b000:  r = alt ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = alt ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  // a_sel: 0 src1, 1 pc.  b_sel: 00 src2, 01 imm, 10 const 4, 11 src2
  logic       a_sel;
  logic [1:0] b_sel;
  alu_op_e    op;
  imm_e       itype;

  always_comb begin
    itype   = IMM_NONE;
    en_wreg = 1'b0;
    en_wmem = 1'b0;
    branch  = 1'b0;
    load    = 1'b0;
    a_sel   = 1'b0;
    b_sel   = 2'b00;
    op      = ALU_ADD;
    unique case (1'b1)
      is_op: begin
        op      = f3_op(f3, f7);
        en_wreg = 1'b1;
      end
      is_opi: begin
        itype   = IMM_I;
        b_sel   = 2'b01;
        op      = f3_op(f3, f7 && (f3 == 3'b101));
        en_wreg = 1'b1;
      end
      is_lui: begin
        itype   = IMM_U;
        b_sel   = 2'b01;
        op      = ALU_COPYB;
        en_wreg = 1'b1;
      end
      is_auipc: begin
        itype   = IMM_U;
        a_sel   = 1'b1;
        b_sel   = 2'b01;
        en_wreg = 1'b1;
      end
      is_jal, is_jalr: begin
        itype   = is_jal ? IMM_J : IMM_I;
        a_sel   = 1'b1;
        b_sel   = 2'b10;
        en_wreg = 1'b1;
      end
      is_load: begin
        itype   = IMM_I;
        b_sel   = 2'b01;
        en_wreg = 1'b1;
        load    = 1'b1;
      end
      is_store: begin
        itype   = IMM_S;
        b_sel   = 2'b01;
        en_wmem = 1'b1;
      end
      is_br: begin
        itype  = IMM_B;
        branch = 1'b1;
        unique case (f3[2:1])
          2'b00:   op = ALU_SUB;
          2'b10:   op = ALU_SLT;
          2'b11:   op = ALU_SLTU;
          default: op = ALU_SUB;
        endcase
      end
      default: ;
    endcase
  end

  assign op_imm  = itype;
  assign alu_sel = op;

  logic [XLEN-1:0] a, b;
  logic [4:0]      shamt;

  assign a = a_sel ? pc : src1;

  always_comb begin
    unique case (b_sel)
      2'b01:   b = imm;
      2'b10:   b = XLEN'(4);
      default: b = src2;
    endcase
  end

  assign shamt = b[4:0];

  always_comb begin
    case (alu_sel)
      4'b0000: result = a + b;
      4'b0001: result = a - b;
      4'b0010: result = a << shamt;
      4'b0011: result = XLEN'($signed(a) < $signed(b));
      4'b0100: result = XLEN'(a < b);
      4'b0101: result = a ^ b;
      4'b0110: result = a >> shamt;
      4'b0111: result = $unsigned($signed(a) >>> shamt);
      4'b1000: result = a | b;
      4'b1001: result = a & b;
      4'b1010: result = b;
      default: result = '0;
    endcase
  end

  assign is_zero = result == '0;

  logic [XLEN-1:0] result_d;
  logic            wen_d;

  always_comb begin
    result_d = result;
    wen_d    = en_wreg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_q <= '0;
      wen_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      wen_q    <= wen_d;
    end
  end

`ifdef EXEC_TRACE_EN
  always @(posedge clk) begin
    if (rst)
      $display("exec pc=%h cmd=%h sel=%b a=%h b=%h res=%h",
               pc, cmd, alu_sel, a, b, result);
  end
`else
`endif

endmodule

// File: tb/tb_rv_exec_unit.sv
// Self-checking bench for rv_exec_unit: comb decode/ALU checks
// plus a queue scoreboard for the registered writeback stage.
module tb_rv_exec_unit;

  logic        clk;
  logic        rst;
  logic [31:0] cmd, pc, src1, src2, imm;
  logic [2:0]  op_imm;
  logic        en_wreg, en_wmem, branch, load;
  logic [3:0]  alu_sel;
  logic [31:0] result;
  logic        is_zero;
  logic [31:0] result_q;
  logic        wen_q;

  rv_exec_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd),
    .pc       (pc),
    .src1     (src1),
    .src2     (src2),
    .imm      (imm),
    .op_imm   (op_imm),
    .en_wreg  (en_wreg),
    .en_wmem  (en_wmem),
    .branch   (branch),
    .load     (load),
    .alu_sel  (alu_sel),
    .result   (result),
    .is_zero  (is_zero),
    .result_q (result_q),
    .wen_q    (wen_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        wen;
  } wb_t;

  wb_t sb[$];
  int  errors = 0;
  int  checks = 0;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // flags = {en_wreg, en_wmem, branch, load}
  task automatic run(input string tag, input logic [31:0] c,
                     input logic [31:0] p, input logic [31:0] s1,
                     input logic [31:0] s2, input logic [31:0] im,
                     input logic [31:0] res, input logic [3:0] sel,
                     input logic [2:0] opi, input logic [3:0] flags);
    wb_t w;
    @(negedge clk);
    cmd = c; pc = p; src1 = s1; src2 = s2; imm = im;
    #1;
    chk({tag, ".result"}, result, res);
    chk({tag, ".sel"}, 32'(alu_sel), 32'(sel));
    chk({tag, ".op_imm"}, 32'(op_imm), 32'(opi));
    chk({tag, ".flags"}, 32'({en_wreg, en_wmem, branch, load}),
        32'(flags));
    chk({tag, ".zero"}, 32'(is_zero), 32'(res == 32'd0));
    sb.push_back('{res: res, wen: flags[3]});
    @(posedge clk);
    #1;
    w = sb.pop_front();
    chk({tag, ".result_q"}, result_q, w.res);
    chk({tag, ".wen_q"}, 32'(wen_q), 32'(w.wen));
  endtask

  initial begin
    rst = 1'b0;
    cmd = 32'h0000007F; pc = '0; src1 = '0; src2 = '0; imm = '0;
    #2;
    chk("rst.result_q", result_q, 32'd0);
    chk("rst.wen_q", 32'(wen_q), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run("addi",  32'h00500093, 0, 0, 0, 5,
        32'd5, 4'b0000, 3'b000, 4'b1000);
    // async reset between edges, held across an edge
    #2 rst = 1'b0;
    #1;
    chk("arst.result_q", result_q, 32'd0);
    chk("arst.wen_q", 32'(wen_q), 32'd0);
    @(posedge clk);
    #1;
    chk("hold.result_q", result_q, 32'd0);
    chk("hold.wen_q", 32'(wen_q), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run("sub",   32'h40208033, 0, 7, 7, 0,
        32'd0, 4'b0001, 3'b111, 4'b1000);
    run("srai",  32'h4011D093, 0, 32'h80000000, 0, 32'h401,
        32'hC0000000, 4'b0111, 3'b000, 4'b1000);
    run("auipc", 32'h00001097, 32'h80000000, 0, 0, 32'h1000,
        32'h80001000, 4'b0000, 3'b011, 4'b1000);
    run("jal",   32'h008000EF, 32'h80000010, 0, 0, 8,
        32'h80000014, 4'b0000, 3'b100, 4'b1000);
    run("jalr",  32'h000080E7, 32'h00000200, 32'h55, 0, 0,
        32'h00000204, 4'b0000, 3'b000, 4'b1000);
    run("sw",    32'h0020A223, 0, 32'h100, 9, 4,
        32'h104, 4'b0000, 3'b001, 4'b0100);
    run("bad",   32'h0000007F, 0, 3, 4, 99,
        32'd7, 4'b0000, 3'b111, 4'b0000);
    run("addwrap", 32'h002081B3, 0, 32'hFFFFFFFF, 1, 0,
        32'd0, 4'b0000, 3'b111, 4'b1000);
    run("slt",   32'h0020A1B3, 0, 32'hFFFFFFFF, 1, 0,
        32'd1, 4'b0011, 3'b111, 4'b1000);
    run("sltu",  32'h0020B1B3, 0, 32'hFFFFFFFF, 1, 0,
        32'd0, 4'b0100, 3'b111, 4'b1000);
    run("sra",   32'h4020D1B3, 0, 32'h80000000, 32'h24, 0,
        32'hF8000000, 4'b0111, 3'b111, 4'b1000);
    run("srl",   32'h0020D1B3, 0, 32'h80000000, 32'h24, 0,
        32'h08000000, 4'b0110, 3'b111, 4'b1000);
    run("sll",   32'h002091B3, 0, 32'h00000003, 32'h3F, 0,
        32'h80000000, 4'b0010, 3'b111, 4'b1000);
    run("and",   32'h0020F1B3, 0, 32'hF0F0F0F0, 32'hFF00FF00, 0,
        32'hF000F000, 4'b1001, 3'b111, 4'b1000);
    run("or",    32'h0020E1B3, 0, 32'hF0F0F0F0, 32'h0F000000, 0,
        32'hFFF0F0F0, 4'b1000, 3'b111, 4'b1000);
    run("xori",  32'h0FF0C093, 0, 32'h0000FFFF, 0, 32'hFF,
        32'h0000FF00, 4'b0101, 3'b000, 4'b1000);
    run("addi30", 32'h40008093, 0, 10, 0, 32'h400,
        32'h40A, 4'b0000, 3'b000, 4'b1000);
    run("blt",   32'h0020C063, 0, 32'hFFFFFFFE, 2, 0,
        32'd1, 4'b0011, 3'b010, 4'b0010);
    run("bgeu",  32'h0020F063, 0, 32'hFFFFFFFE, 2, 0,
        32'd0, 4'b0100, 3'b010, 4'b0010);
    run("beq",   32'h00208063, 0, 32'h1234, 32'h1234, 0,
        32'd0, 4'b0001, 3'b010, 4'b0010);
    run("lui",   32'h123450B7, 0, 32'h77, 32'h88, 32'h12345000,
        32'h12345000, 4'b1010, 3'b011, 4'b1000);
    run("lw",    32'h0040A083, 0, 32'h1000, 0, 4,
        32'h1004, 4'b0000, 3'b000, 4'b1001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
